// File: rtl/alu_issue.sv
// Decodes RV32I ALU/branch/jump instructions into ALU operations and issues them through a 2-entry skid buffer.
// Latency 1 cycle when empty; instr_ready_o drops only when the skid entry is occupied, never combinationally from alu_ready_i.
module alu_issue (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    output logic [4:0]  aluc_o,
    output logic [31:0] A_o,
    output logic [31:0] B_o,
    output logic [4:0]  rd_o,
    output logic        wb_en_o,
    output logic        illegal_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_BEQ  = 5'b01110;
    localparam logic [4:0] ALU_BNE  = 5'b01111;
    localparam logic [4:0] ALU_BLT  = 5'b10100;
    localparam logic [4:0] ALU_BGE  = 5'b10001;
    localparam logic [4:0] ALU_BLTU = 5'b10110;
    localparam logic [4:0] ALU_BGEU = 5'b10011;
    localparam logic [4:0] ALU_JUMP = 5'b11111;

    typedef struct packed {
        logic [4:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb_en;
        logic        illegal;
    } entry_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        unused_rs1_field;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign rd_field = instr_i[11:7];
    assign imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_u    = {instr_i[31:12], 12'b0};
    assign shamt    = {27'b0, instr_i[24:20]};

    // Register operands arrive already read, so the rs1 index itself is not needed here.
    assign unused_rs1_field = ^instr_i[19:15];

    entry_t dec;
    logic   legal;
    logic   writes;

    always_comb begin
        dec    = '0;
        legal  = 1'b1;
        writes = 1'b1;
        dec.rd = rd_field;
        case (opcode)
            OPC_OP: begin
                dec.a = rs1_data_i;
                dec.b = rs2_data_i;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec.aluc = ALU_ADD;
                    {F7_BASE, 3'b001}: dec.aluc = ALU_SLL;
                    {F7_BASE, 3'b010}: dec.aluc = ALU_SLT;
                    {F7_BASE, 3'b011}: dec.aluc = ALU_SLTU;
                    {F7_BASE, 3'b100}: dec.aluc = ALU_XOR;
                    {F7_BASE, 3'b101}: dec.aluc = ALU_SRL;
                    {F7_BASE, 3'b110}: dec.aluc = ALU_OR;
                    {F7_BASE, 3'b111}: dec.aluc = ALU_AND;
                    {F7_ALT,  3'b000}: dec.aluc = ALU_SUB;
                    {F7_ALT,  3'b101}: dec.aluc = ALU_SRA;
                    default:           legal    = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec.a = rs1_data_i;
                dec.b = imm_i;
                case (funct3)
                    3'b000: dec.aluc = ALU_ADD;
                    3'b010: dec.aluc = ALU_SLT;
                    3'b011: dec.aluc = ALU_SLTU;
                    3'b100: dec.aluc = ALU_XOR;
                    3'b110: dec.aluc = ALU_OR;
                    3'b111: dec.aluc = ALU_AND;
                    3'b001: begin
                        dec.b    = shamt;
                        dec.aluc = ALU_SLL;
                        legal    = (funct7 == F7_BASE);
                    end
                    default: begin
                        dec.b = shamt;
                        if (funct7 == F7_BASE) begin
                            dec.aluc = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec.aluc = ALU_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                endcase
            end
            OPC_BRANCH: begin
                // Branch rd bits carry immediate, so no destination is reported.
                dec.a  = rs1_data_i;
                dec.b  = rs2_data_i;
                dec.rd = 5'd0;
                writes = 1'b0;
                case (funct3)
                    3'b000:  dec.aluc = ALU_BEQ;
                    3'b001:  dec.aluc = ALU_BNE;
                    3'b100:  dec.aluc = ALU_BLT;
                    3'b101:  dec.aluc = ALU_BGE;
                    3'b110:  dec.aluc = ALU_BLTU;
                    3'b111:  dec.aluc = ALU_BGEU;
                    default: legal    = 1'b0;
                endcase
            end
            OPC_JAL: begin
                dec.aluc = ALU_JUMP;
                dec.a    = pc_i + 32'd4;
            end
            OPC_JALR: begin
                dec.aluc = ALU_JUMP;
                dec.a    = pc_i + 32'd4;
                legal    = (funct3 == 3'b000);
            end
            OPC_LUI: begin
                dec.aluc = ALU_ADD;
                dec.b    = imm_u;
            end
            OPC_AUIPC: begin
                dec.aluc = ALU_ADD;
                dec.a    = pc_i;
                dec.b    = imm_u;
            end
            default: legal = 1'b0;
        endcase

        dec.wb_en = writes && (rd_field != 5'd0);
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    entry_t main_q;
    entry_t skid_q;
    logic   main_vld;
    logic   skid_vld;
    logic   accept;
    logic   xfer;

    assign accept = instr_valid_i && !skid_vld;
    assign xfer   = main_vld && alu_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (xfer) begin
            // With skid occupied no accept is possible, so only the drain applies.
            if (skid_vld) begin
                main_q   <= skid_q;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_q <= dec;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!main_vld) begin
                main_q   <= dec;
                main_vld <= 1'b1;
            end else begin
                skid_q   <= dec;
                skid_vld <= 1'b1;
            end
        end
    end

    assign instr_ready_o = !skid_vld;
    assign alu_valid_o   = main_vld;
    assign aluc_o        = main_q.aluc;
    assign A_o           = main_q.a;
    assign B_o           = main_q.b;
    assign rd_o          = main_q.rd;
    assign wb_en_o       = main_q.wb_en;
    assign illegal_o     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed decode cases, skid backpressure, mid-run reset, and a randomized scoreboard run.
module tb_alu_issue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        alu_valid_o;
    logic        alu_ready_i;
    logic [4:0]  aluc_o;
    logic [31:0] A_o;
    logic [31:0] B_o;
    logic [4:0]  rd_o;
    logic        wb_en_o;
    logic        illegal_o;

    alu_issue dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .alu_valid_o   (alu_valid_o),
        .alu_ready_i   (alu_ready_i),
        .aluc_o        (aluc_o),
        .A_o           (A_o),
        .B_o           (B_o),
        .rd_o          (rd_o),
        .wb_en_o       (wb_en_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        ill;
        logic [4:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // Reference decode: base/alt ops share the funct3 numbering with funct7[5] as bit 3.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [4:0] br_tab [0:7];
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        logic       writes;
        logic       shift;
        br_tab = '{5'b01110, 5'b01111, 5'b00000, 5'b00000, 5'b10100, 5'b10001, 5'b10110, 5'b10011};
        e      = '0;
        opc    = ins[6:0];
        f3     = ins[14:12];
        f7     = ins[31:25];
        ok     = 1'b0;
        writes = 1'b0;
        shift  = (f3 == 3'd1) || (f3 == 3'd5);
        if (opc == 7'h33 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) begin
            ok = 1'b1; writes = 1'b1;
            e.aluc = {1'b0, f7[5], f3}; e.a = r1; e.b = r2;
        end else if (opc == 7'h13 && (!shift || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20))) begin
            ok = 1'b1; writes = 1'b1;
            e.aluc = shift ? {1'b0, f7[5], f3} : {2'b00, f3};
            e.a = r1;
            e.b = shift ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
        end else if (opc == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
            ok = 1'b1;
            e.aluc = br_tab[f3]; e.a = r1; e.b = r2;
        end else if (opc == 7'h6F || (opc == 7'h67 && f3 == 3'd0)) begin
            ok = 1'b1; writes = 1'b1;
            e.aluc = 5'd31; e.a = pc + 32'd4; e.b = 32'd0;
        end else if (opc == 7'h37 || opc == 7'h17) begin
            ok = 1'b1; writes = 1'b1;
            e.aluc = 5'd0; e.a = (opc == 7'h17) ? pc : 32'd0; e.b = ins & 32'hFFFFF000;
        end
        if (ok) begin
            e.rd = writes ? ins[11:7] : 5'd0;
            e.wb = writes && (ins[11:7] != 5'd0);
        end else begin
            e     = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t observed();
        return {illegal_o, aluc_o, A_o, B_o, rd_o, wb_en_o};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        int          sel;
        w   = $urandom;
        k   = $urandom_range(0, 9);
        sel = $urandom_range(0, 2);
        case (k)
            0, 1: w[6:0] = 7'h33;
            2, 3: w[6:0] = 7'h13;
            4:    w[6:0] = 7'h63;
            5:    w[6:0] = 7'h6F;
            6:    w[6:0] = 7'h67;
            7:    w[6:0] = 7'h37;
            8:    w[6:0] = 7'h17;
            default: ;
        endcase
        if (sel == 0) w[31:25] = 7'h00;
        else if (sel == 1) w[31:25] = 7'h20;
        if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        instr_valid_i = v;
        instr_i       = ins;
        pc_i          = pc;
        rs1_data_i    = r1;
        rs2_data_i    = r2;
    endtask

    // Presents one instruction with the sink ready and returns at the next negedge.
    task automatic send_one(input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] r1, input logic [31:0] r2);
        @(negedge clk_i);
        alu_ready_i = 1'b1;
        drive(1'b1, ins, pc, r1, r2);
        @(negedge clk_i);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        alu_ready_i = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        #12;
        checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", alu_valid_o); end
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", instr_ready_o); end
        checks++;
        if ({aluc_o, A_o, B_o, rd_o, wb_en_o, illegal_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got aluc=%h A=%h B=%h rd=%h wb=%b ill=%b exp all 0",
                     aluc_o, A_o, B_o, rd_o, wb_en_o, illegal_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_addi();
        send_one(32'hFFD08293, 32'h0, 32'd10, 32'd0);
        checks++;
        if (alu_valid_o !== 1'b1 || aluc_o !== 5'b00000 || A_o !== 32'd10 || B_o !== 32'hFFFFFFFD
            || rd_o !== 5'd5 || wb_en_o !== 1'b1 || illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL addi got v=%b aluc=%b A=%h B=%h rd=%0d wb=%b ill=%b exp v=1 aluc=00000 A=0000000a B=fffffffd rd=5 wb=1 ill=0",
                     alu_valid_o, aluc_o, A_o, B_o, rd_o, wb_en_o, illegal_o);
        end
        @(negedge clk_i);
        checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL addi_drain got %b exp 0", alu_valid_o); end
    endtask

    task automatic test_beq();
        send_one(32'h00208463, 32'h0, 32'd7, 32'd7);
        checks++;
        if (alu_valid_o !== 1'b1 || aluc_o !== 5'b01110 || A_o !== 32'd7 || B_o !== 32'd7
            || wb_en_o !== 1'b0 || illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL beq got v=%b aluc=%b A=%h B=%h wb=%b ill=%b exp v=1 aluc=01110 A=7 B=7 wb=0 ill=0",
                     alu_valid_o, aluc_o, A_o, B_o, wb_en_o, illegal_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_jal();
        send_one(32'h008000EF, 32'h100, 32'hDEAD, 32'hBEEF);
        checks++;
        if (alu_valid_o !== 1'b1 || aluc_o !== 5'b11111 || A_o !== 32'h104 || B_o !== 32'd0
            || rd_o !== 5'd1 || wb_en_o !== 1'b1) begin
            errors++;
            $display("FAIL jal got v=%b aluc=%b A=%h B=%h rd=%0d wb=%b exp v=1 aluc=11111 A=104 B=0 rd=1 wb=1",
                     alu_valid_o, aluc_o, A_o, B_o, rd_o, wb_en_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_illegal();
        send_one(32'h00000000, 32'h40, 32'h1234, 32'h5678);
        checks++;
        if (alu_valid_o !== 1'b1 || illegal_o !== 1'b1 || aluc_o !== 5'd0 || wb_en_o !== 1'b0
            || A_o !== 32'd0 || B_o !== 32'd0) begin
            errors++;
            $display("FAIL illegal got v=%b ill=%b aluc=%b wb=%b A=%h B=%h exp v=1 ill=1 aluc=0 wb=0 A=0 B=0",
                     alu_valid_o, illegal_o, aluc_o, wb_en_o, A_o, B_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        alu_ready_i = 1'b0;
        drive(1'b1, 32'h00008093, 32'h0, 32'd100, 32'd0);
        @(negedge clk_i);
        checks++; if (instr_ready_o !== 1'b1 || A_o !== 32'd100) begin errors++; $display("FAIL bp_i0 got rdy=%b A=%0d exp rdy=1 A=100", instr_ready_o, A_o); end
        rs1_data_i = 32'd200;
        @(negedge clk_i);
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full got rdy=%b exp 0", instr_ready_o); end
        rs1_data_i = 32'd300;
        @(negedge clk_i);
        checks++;
        if (instr_ready_o !== 1'b0 || alu_valid_o !== 1'b1 || A_o !== 32'd100) begin
            errors++;
            $display("FAIL bp_hold got rdy=%b v=%b A=%0d exp rdy=0 v=1 A=100", instr_ready_o, alu_valid_o, A_o);
        end
        alu_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (alu_valid_o !== 1'b1 || A_o !== 32'd200) begin errors++; $display("FAIL bp_i1 got v=%b A=%0d exp v=1 A=200", alu_valid_o, A_o); end
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        checks++; if (alu_valid_o !== 1'b1 || A_o !== 32'd300) begin errors++; $display("FAIL bp_i2 got v=%b A=%0d exp v=1 A=300", alu_valid_o, A_o); end
        @(negedge clk_i);
        checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", alu_valid_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        alu_ready_i = 1'b0;
        drive(1'b1, 32'h00008093, 32'h0, 32'd11, 32'd0);
        @(negedge clk_i);
        rs1_data_i = 32'd22;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL rm_full got rdy=%b exp 0", instr_ready_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (alu_valid_o !== 1'b0 || instr_ready_o !== 1'b1 || A_o !== 32'd0 || aluc_o !== 5'd0) begin
            errors++;
            $display("FAIL rm_async got v=%b rdy=%b A=%h aluc=%b exp v=0 rdy=1 A=0 aluc=0",
                     alu_valid_o, instr_ready_o, A_o, aluc_o);
        end
        @(negedge clk_i);
        rst_ni      = 1'b1;
        alu_ready_i = 1'b1;
        drive(1'b1, 32'h00008093, 32'h0, 32'h55, 32'd0);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        checks++; if (alu_valid_o !== 1'b1 || A_o !== 32'h55) begin errors++; $display("FAIL rm_after got v=%b A=%h exp v=1 A=55", alu_valid_o, A_o); end
        @(negedge clk_i);
        checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL rm_drain got %b exp 0", alu_valid_o); end
    endtask

    // One negedge step of the scoreboard: occupancy, head-of-queue match, pop on transfer, push on accept.
    task automatic scoreboard_step();
        exp_t got;
        checks++; if (alu_valid_o !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid got %b exp %b", alu_valid_o, q.size() > 0); end
        checks++; if (instr_ready_o !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready got %b exp %b", instr_ready_o, q.size() < 2); end
        if (alu_valid_o === 1'b1 && q.size() > 0) begin
            got = observed();
            checks++;
            if (got !== q[0]) begin errors++; $display("FAIL rnd_entry got %h exp %h", got, q[0]); end
            if (alu_ready_i) void'(q.pop_front());
        end
        if (instr_valid_i && instr_ready_o) q.push_back(ref_model(instr_i, pc_i, rs1_data_i, rs2_data_i));
    endtask

    task automatic test_random();
        q.delete();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            alu_ready_i = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 2) != 0, rand_instr(), $urandom, $urandom, $urandom);
            scoreboard_step();
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            alu_ready_i = 1'b1;
            drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
            scoreboard_step();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_leftover got %0d entries exp 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_beq();
        test_jal();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset: clk_i and rst_ni.
REQ-002 SHALL have these ports, in this order:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- instr_valid_i  in  1  upstream instruction valid
- instr_ready_o  out  1  block can accept an instruction
- instr_i  in  32  RV32I instruction word
- pc_i  in  32  instruction PC
- rs1_data_i  in  32  rs1 register value
- rs2_data_i  in  32  rs2 register value
- alu_valid_o  out  1  ALU operation valid
- alu_ready_i  in  1  ALU/execute stage accepts operation
- aluc_o  out  5  ALU operation code
- A_o  out  32  ALU operand A
- B_o  out  32  ALU operand B
- rd_o  out  5  destination register
- wb_en_o  out  1  result is written back
- illegal_o  out  1  instruction not decoded

Function
REQ-003 SHALL use these aluc codes: ADD 00000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, OR 00110, AND 00111, SUB 01000, SRA 01101, BEQ 01110, BNE 01111, BLT 10100, BGE 10001, BLTU 10110, BGEU 10011, JAL/JALR 11111.
REQ-004 SHALL map OP (0110011) and OP-IMM (0010011) by funct3/funct7 as follows:
- A_o = rs1.
- B_o = rs2 for OP, or the sign-extended I-imm for OP-IMM.
- For SLLI/SRLI/SRAI, B_o = {27'b0, imm[4:0]}.
REQ-005 SHALL map BRANCH (1100011) funct3 000/001/100/101/110/111 to BEQ/BNE/BLT/BGE/BLTU/BGEU, with A_o = rs1, B_o = rs2 and wb_en_o = 0.
REQ-006 SHALL map JAL (1101111) and JALR (1100111, funct3 000) to code 11111, with A_o = pc_i + 4 (mod 2^32) and B_o = 0.
REQ-007 SHALL map LUI to ADD with A_o = 0, B_o = {imm[31:12], 12'b0}, and AUIPC to ADD with A_o = pc_i and the same B_o.
REQ-008 SHALL treat every other encoding as illegal: illegal_o = 1, aluc_o = 00000, A_o = B_o = 0, wb_en_o = 0; the entry still flows through the handshake.
REQ-009 SHALL force wb_en_o = 0 whenever rd == 0.
REQ-010 SHALL accept an instruction on a clock edge where instr_valid_i && instr_ready_o, sampling instr_i, pc_i, rs1_data_i and rs2_data_i on that edge.
REQ-011 SHALL complete an output transfer on a clock edge where alu_valid_o && alu_ready_i.
REQ-012 SHALL buffer up to two decoded entries: a main register driving the outputs plus one skid register.
REQ-013 SHALL drive instr_ready_o = !skid_valid, from registered state only, with no combinational path from alu_ready_i.
REQ-014 SHALL present an entry accepted into an empty block on the outputs on the cycle after acceptance (1-cycle latency).
REQ-015 SHALL handle each case as follows:
- Accept with main empty, or accept together with a transfer while skid is empty: the new entry loads main.
- Accept while main is valid and not transferring: the new entry loads skid.
- Transfer while skid is valid: skid moves into main.
REQ-016 SHALL preserve program order, with no loss or duplication.
REQ-017 SHALL hold outputs stable while alu_valid_o = 1 and alu_ready_i = 0.

Reset
REQ-018 SHALL, while rst_ni = 0 and independent of the clock, drive alu_valid_o = 0, instr_ready_o = 1, aluc_o = 0, A_o = 0, B_o = 0, rd_o = 0, wb_en_o = 0 and illegal_o = 0, and clear both buffer entries.
REQ-019 SHALL discard any buffered entries when reset is asserted mid-operation, and SHALL accept again on the first clock edge after rst_ni rises.

Verification
REQ-020 ADDI: instr 0xFFD08293, rs1 = 10, alu_ready_i = 1 -> next cycle alu_valid_o = 1, aluc = 00000, A = 10, B = 0xFFFFFFFD, rd = 5, wb_en = 1.
REQ-021 BEQ: 0x00208463, rs1 = 7, rs2 = 7 -> aluc = 01110, A = 7, B = 7, wb_en = 0, illegal = 0.
REQ-022 JAL: 0x008000EF, pc = 0x100 -> aluc = 11111, A = 0x104, B = 0, rd = 1, wb_en = 1.
REQ-023 Illegal: instr 0x00000000 -> alu_valid_o = 1, illegal = 1, aluc = 0, wb_en = 0.
REQ-024 Backpressure: alu_ready_i = 0, three back-to-back instrs I0, I1, I2:
- I0 and I1 are accepted; instr_ready_o = 0 after the I1 accept; I2 is held.
- Raise alu_ready_i: outputs I0, I1, I2 in order, with no gaps.
REQ-025 Reset mid-operation: both entries full, pull rst_ni low between edges:
- alu_valid_o = 0 and instr_ready_o = 1 immediately.
- After release, a new instruction appears with 1-cycle latency.
